// File: rtl/apb_access_phase.sv
// rtl/apb_access_phase.sv - passive APB phase classifier, transfer counter and protocol checker
module apb_access_phase #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  checks_en,
    input  logic                  clr_err,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr,
    output logic                  setup_phase,
    output logic                  access_phase,
    output logic                  xfer_done,
    output logic [31:0]           xfer_count,
    output logic [15:0]           slverr_count,
    output logic [6:0]            err_pulse,
    output logic [6:0]            err_sticky,
    output logic [15:0]           err_count
);

    // Check bit positions within err_pulse / err_sticky
    localparam int PENABLE_EXIT          = 0;
    localparam int PENABLE_DROP          = 1;
    localparam int PWRITE_STABLE         = 2;
    localparam int PADDR_STABLE          = 3;
    localparam int PWDATA_STABLE         = 4;
    localparam int PENABLE_IN_SETUP      = 5;
    localparam int NO_ACCESS_AFTER_SETUP = 6;

    // History of the previous sampled bus cycle
    logic                  prev_psel_q,    prev_psel_d;
    logic                  prev_penable_q, prev_penable_d;
    logic                  prev_pready_q,  prev_pready_d;
    logic                  prev_pwrite_q,  prev_pwrite_d;
    logic [ADDR_WIDTH-1:0] prev_paddr_q,   prev_paddr_d;
    logic [DATA_WIDTH-1:0] prev_pwdata_q,  prev_pwdata_d;
    logic                  prev_access_q,  prev_access_d;
    logic                  prev_setup_q,   prev_setup_d;
    logic                  hist_valid_q,   hist_valid_d;

    // Registered outputs
    logic [31:0] xfer_count_q,   xfer_count_d;
    logic [15:0] slverr_count_q, slverr_count_d;
    logic [6:0]  err_pulse_q,    err_pulse_d;
    logic [6:0]  err_sticky_q,   err_sticky_d;
    logic [15:0] err_count_q,    err_count_d;

    logic [6:0]  chk_raw;
    logic [6:0]  chk_fire;
    logic [2:0]  fire_cnt;
    logic [15:0] err_count_base;
    logic [16:0] err_sum;

    // Read data is observed for completeness but no rule applies to it
    logic unused_prdata;
    assign unused_prdata = ^prdata;

    // A select cycle is setup when it starts a transfer or follows a completion
    assign setup_phase  = psel & (~prev_psel_q | prev_pready_q);
    assign access_phase = psel & penable;
    assign xfer_done    = access_phase & pready;

    assign xfer_count   = xfer_count_q;
    assign slverr_count = slverr_count_q;
    assign err_pulse    = err_pulse_q;
    assign err_sticky   = err_sticky_q;
    assign err_count    = err_count_q;

    // Evaluate the protocol rules and compute every next-state value
    always_comb begin
        chk_raw                        = '0;
        chk_raw[PENABLE_EXIT]          = prev_access_q & prev_pready_q & penable;
        chk_raw[PENABLE_DROP]          = prev_access_q & ~prev_pready_q & ~penable;
        chk_raw[PWRITE_STABLE]         = access_phase & (pwrite != prev_pwrite_q);
        chk_raw[PADDR_STABLE]          = access_phase & (paddr != prev_paddr_q);
        chk_raw[PWDATA_STABLE]         = access_phase & pwrite & (pwdata != prev_pwdata_q);
        chk_raw[PENABLE_IN_SETUP]      = setup_phase & penable;
        chk_raw[NO_ACCESS_AFTER_SETUP] = prev_setup_q & ~penable;

        // The first sample after reset has no valid history to compare against
        chk_fire = chk_raw & {7{checks_en & hist_valid_q}};

        fire_cnt = '0;
        for (int i = 0; i < 7; i++) begin
            fire_cnt = fire_cnt + {2'b00, chk_fire[i]};
        end

        // Clear first, then record this edge's violations so a new event survives clr_err
        err_count_base = clr_err ? 16'h0000 : err_count_q;
        err_sum        = {1'b0, err_count_base} + {14'b0, fire_cnt};
        err_count_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        err_sticky_d   = (clr_err ? 7'h00 : err_sticky_q) | chk_fire;
        err_pulse_d    = chk_fire;

        xfer_count_d   = xfer_done ? (xfer_count_q + 32'd1) : xfer_count_q;
        slverr_count_d = slverr_count_q;
        if (xfer_done && pslverr && (slverr_count_q != 16'hFFFF)) begin
            slverr_count_d = slverr_count_q + 16'd1;
        end

        prev_psel_d    = psel;
        prev_penable_d = penable;
        prev_pready_d  = pready;
        prev_pwrite_d  = pwrite;
        prev_paddr_d   = paddr;
        prev_pwdata_d  = pwdata;
        prev_access_d  = access_phase;
        prev_setup_d   = setup_phase;
        hist_valid_d   = 1'b1;
    end

    // State update; reset wipes history and outputs immediately
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            prev_psel_q    <= 1'b0;
            prev_penable_q <= 1'b0;
            prev_pready_q  <= 1'b0;
            prev_pwrite_q  <= 1'b0;
            prev_paddr_q   <= '0;
            prev_pwdata_q  <= '0;
            prev_access_q  <= 1'b0;
            prev_setup_q   <= 1'b0;
            hist_valid_q   <= 1'b0;
            xfer_count_q   <= '0;
            slverr_count_q <= '0;
            err_pulse_q    <= '0;
            err_sticky_q   <= '0;
            err_count_q    <= '0;
        end else begin
            prev_psel_q    <= prev_psel_d;
            prev_penable_q <= prev_penable_d;
            prev_pready_q  <= prev_pready_d;
            prev_pwrite_q  <= prev_pwrite_d;
            prev_paddr_q   <= prev_paddr_d;
            prev_pwdata_q  <= prev_pwdata_d;
            prev_access_q  <= prev_access_d;
            prev_setup_q   <= prev_setup_d;
            hist_valid_q   <= hist_valid_d;
            xfer_count_q   <= xfer_count_d;
            slverr_count_q <= slverr_count_d;
            err_pulse_q    <= err_pulse_d;
            err_sticky_q   <= err_sticky_d;
            err_count_q    <= err_count_d;
        end
    end

endmodule

// File: tb/tb_apb_access_phase.sv
// tb/tb_apb_access_phase.sv - directed vector bench for apb_access_phase
module tb_apb_access_phase;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        checks_en = 1'b1;
    logic        clr_err = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready = 1'b0;
    logic [31:0] prdata = 32'hDEAD_BEEF;
    logic        pslverr = 1'b0;
    logic        setup_phase, access_phase, xfer_done;
    logic [31:0] xfer_count;
    logic [15:0] slverr_count;
    logic [6:0]  err_pulse, err_sticky;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_access_phase #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .pclk(pclk), .preset(preset), .checks_en(checks_en), .clr_err(clr_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .setup_phase(setup_phase), .access_phase(access_phase), .xfer_done(xfer_done),
        .xfer_count(xfer_count), .slverr_count(slverr_count), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    typedef struct {
        logic        rst, en, clr, sel, ena, wr;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        rdy, serr;
        logic        e_setup, e_acc, e_done;
        logic [6:0]  e_pulse, e_sticky;
        logic [15:0] e_ecnt;
        logic [31:0] e_xcnt;
        logic [15:0] e_scnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic rst, logic en, logic clr, logic sel, logic ena, logic wr,
        logic [15:0] addr, logic [31:0] wd, logic rdy, logic serr,
        logic es, logic ea, logic ed,
        logic [6:0] ep, logic [6:0] est, logic [15:0] ec, logic [31:0] ex, logic [15:0] esl);
        vec_t v;
        v.rst = rst; v.en = en; v.clr = clr; v.sel = sel; v.ena = ena; v.wr = wr;
        v.addr = addr; v.wd = wd; v.rdy = rdy; v.serr = serr;
        v.e_setup = es; v.e_acc = ea; v.e_done = ed;
        v.e_pulse = ep; v.e_sticky = est; v.e_ecnt = ec; v.e_xcnt = ex; v.e_scnt = esl;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic clr, input logic sel,
                         input logic ena, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wd, input logic rdy, input logic serr);
        preset = rst; checks_en = en; clr_err = clr; psel = sel; penable = ena;
        pwrite = wr; paddr = addr; pwdata = wd; pready = rdy; pslverr = serr;
    endtask

    initial begin
        //               rst en clr sel ena wr addr      wdata          rdy serr  su ac dn  pulse  stick  ecnt xcnt scnt
        vecs.push_back(mk(1, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h00, 0, 0, 0));
        // legal write, no wait states
        vecs.push_back(mk(0, 1, 0,  1,  0,  1, 16'h0010, 32'hA5A5_0001,  0, 0,   1, 0, 0, 7'h00, 7'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0010, 32'hA5A5_0001,  1, 0,   0, 1, 1, 7'h00, 7'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h00, 0, 1, 0));
        // legal read, three wait states, slave error on completion
        vecs.push_back(mk(0, 1, 0,  1,  0,  0, 16'h0020, 32'h0,          0, 0,   1, 0, 0, 7'h00, 7'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1,  0, 16'h0020, 32'h0,          0, 0,   0, 1, 0, 7'h00, 7'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1,  0, 16'h0020, 32'h0,          0, 0,   0, 1, 0, 7'h00, 7'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1,  0, 16'h0020, 32'h0,          0, 0,   0, 1, 0, 7'h00, 7'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1,  0, 16'h0020, 32'h0,          1, 1,   0, 1, 1, 7'h00, 7'h00, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h00, 0, 2, 1));
        // paddr changes in the second wait cycle
        vecs.push_back(mk(0, 1, 0,  1,  0,  1, 16'h0010, 32'hA5A5_0002,  0, 0,   1, 0, 0, 7'h00, 7'h00, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0010, 32'hA5A5_0002,  0, 0,   0, 1, 0, 7'h00, 7'h00, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0014, 32'hA5A5_0002,  0, 0,   0, 1, 0, 7'h08, 7'h08, 1, 2, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0014, 32'hA5A5_0002,  1, 0,   0, 1, 1, 7'h00, 7'h08, 1, 3, 1));
        vecs.push_back(mk(0, 1, 1,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h00, 0, 3, 1));
        // penable held after completion with psel held
        vecs.push_back(mk(0, 1, 0,  1,  0,  1, 16'h0030, 32'h1111_2222,  0, 0,   1, 0, 0, 7'h00, 7'h00, 0, 3, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0030, 32'h1111_2222,  1, 0,   0, 1, 1, 7'h00, 7'h00, 0, 4, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0030, 32'h1111_2222,  0, 0,   1, 1, 0, 7'h21, 7'h21, 2, 4, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0030, 32'h1111_2222,  1, 0,   0, 1, 1, 7'h00, 7'h21, 2, 5, 1));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h21, 2, 5, 1));
        // same paddr violation with checks masked, then clear
        vecs.push_back(mk(0, 0, 0,  1,  0,  1, 16'h0010, 32'hA5A5_0003,  0, 0,   1, 0, 0, 7'h00, 7'h21, 2, 5, 1));
        vecs.push_back(mk(0, 0, 0,  1,  1,  1, 16'h0010, 32'hA5A5_0003,  0, 0,   0, 1, 0, 7'h00, 7'h21, 2, 5, 1));
        vecs.push_back(mk(0, 0, 0,  1,  1,  1, 16'h0014, 32'hA5A5_0003,  0, 0,   0, 1, 0, 7'h00, 7'h21, 2, 5, 1));
        vecs.push_back(mk(0, 0, 0,  1,  1,  1, 16'h0014, 32'hA5A5_0003,  1, 0,   0, 1, 1, 7'h00, 7'h21, 2, 6, 1));
        vecs.push_back(mk(0, 1, 1,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h00, 0, 6, 1));
        // clear and new violation on the same edge: the violation is kept
        vecs.push_back(mk(0, 1, 1,  1,  1,  0, 16'h0000, 32'h0,          0, 0,   1, 1, 0, 7'h20, 7'h20, 1, 6, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  0, 16'h0000, 32'h0,          1, 0,   0, 1, 1, 7'h00, 7'h20, 1, 7, 1));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h20, 1, 7, 1));
        // setup not followed by access
        vecs.push_back(mk(0, 1, 0,  1,  0,  0, 16'h0000, 32'h0,          0, 0,   1, 0, 0, 7'h00, 7'h20, 1, 7, 1));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h40, 7'h60, 2, 7, 1));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h60, 2, 7, 1));
        // pwdata change, pwrite change, then aborted access
        vecs.push_back(mk(0, 1, 0,  1,  0,  1, 16'h0000, 32'h0,          0, 0,   1, 0, 0, 7'h00, 7'h60, 2, 7, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0000, 32'h0,          0, 0,   0, 1, 0, 7'h00, 7'h60, 2, 7, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0000, 32'h1,          0, 0,   0, 1, 0, 7'h10, 7'h70, 3, 7, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  0, 16'h0000, 32'h1,          0, 0,   0, 1, 0, 7'h04, 7'h74, 4, 7, 1));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h02, 7'h76, 5, 7, 1));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h76, 5, 7, 1));
        // reset mid-access, transfer resumes in access phase
        vecs.push_back(mk(0, 1, 0,  1,  0,  1, 16'h0040, 32'h0,          0, 0,   1, 0, 0, 7'h00, 7'h76, 5, 7, 1));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0040, 32'h0,          0, 0,   0, 1, 0, 7'h00, 7'h76, 5, 7, 1));
        vecs.push_back(mk(1, 1, 0,  1,  1,  1, 16'h0040, 32'h0,          0, 0,   1, 1, 0, 7'h00, 7'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0040, 32'h0,          0, 0,   1, 1, 0, 7'h00, 7'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1,  1, 16'h0040, 32'h0,          1, 0,   0, 1, 1, 7'h00, 7'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,  0,  0,  0, 16'h0000, 32'h0,          0, 0,   0, 0, 0, 7'h00, 7'h00, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge pclk);
            drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].sel, vecs[i].ena, vecs[i].wr,
                  vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].serr);
            #1;
            chk("setup_phase", i, {31'b0, setup_phase}, {31'b0, vecs[i].e_setup});
            chk("access_phase", i, {31'b0, access_phase}, {31'b0, vecs[i].e_acc});
            chk("xfer_done", i, {31'b0, xfer_done}, {31'b0, vecs[i].e_done});
            @(posedge pclk);
            #1;
            chk("err_pulse", i, {25'b0, err_pulse}, {25'b0, vecs[i].e_pulse});
            chk("err_sticky", i, {25'b0, err_sticky}, {25'b0, vecs[i].e_sticky});
            chk("err_count", i, {16'b0, err_count}, {16'b0, vecs[i].e_ecnt});
            chk("xfer_count", i, xfer_count, vecs[i].e_xcnt);
            chk("slverr_count", i, {16'b0, slverr_count}, {16'b0, vecs[i].e_scnt});
        end

        // Long wait-state read: legal for any length, completes once
        @(negedge pclk);
        drive(0, 1, 0, 1, 0, 0, 16'h0100, 32'h0, 0, 0);
        @(posedge pclk);
        for (int w = 0; w < 20; w++) begin
            @(negedge pclk);
            drive(0, 1, 0, 1, 1, 0, 16'h0100, 32'h0, 0, 0);
            #1;
            chk("long_wait_access", 100 + w, {31'b0, access_phase}, 32'd1);
            chk("long_wait_done", 100 + w, {31'b0, xfer_done}, 32'd0);
            @(posedge pclk);
            #1;
            chk("long_wait_pulse", 100 + w, {25'b0, err_pulse}, 32'd0);
        end
        @(negedge pclk);
        drive(0, 1, 0, 1, 1, 0, 16'h0100, 32'h0, 1, 0);
        @(posedge pclk);
        #1;
        chk("long_wait_xfer_count", 200, xfer_count, 32'd2);
        chk("long_wait_slverr_count", 200, {16'b0, slverr_count}, 32'd0);
        @(negedge pclk);
        drive(0, 1, 0, 0, 0, 0, 16'h0000, 32'h0, 0, 0);
        @(posedge pclk);
        #1;
        chk("long_wait_sticky", 201, {25'b0, err_sticky}, 32'd0);
        chk("long_wait_err_count", 201, {16'b0, err_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
